// File: rtl/key_scan_tx.sv
// key_scan_tx: debounces NUM_KEYS active-low keys on a shared sample tick,
// queues presses (and optional auto-repeats) as pending requests, and sends
// one byte per request to a UART transmitter over a wrsig/busy handshake.
module key_scan_tx #(
   parameter int unsigned NUM_KEYS      = 4,
   parameter int unsigned SAMPLE_CYCLES = 1000000,
   parameter logic [7:0]  BASE_CODE     = 8'd49,
   parameter int unsigned REPEAT_TICKS  = 0,
   parameter int unsigned BUSY_TIMEOUT  = 16
) (
   input  logic                clk_50MHz,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key,
   input  logic                uart_busy,
   output logic                uart_wrsig,
   output logic [7:0]          uart_datain,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                drop_pulse
);

   localparam int unsigned TICK_W = $clog2(SAMPLE_CYCLES);
   localparam int unsigned REP_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam int unsigned TO_W   = $clog2(BUSY_TIMEOUT + 1);
   localparam int unsigned IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t              state;
   logic [NUM_KEYS-1:0] sync1, sync2;
   logic [NUM_KEYS-1:0] sample, stable, stable_q;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick;
   logic [REP_W-1:0]    rep_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] press, release_now, rep_evt, evt;
   logic [NUM_KEYS-1:0] pending, clr_mask;
   logic [TO_W-1:0]     to_cnt;
   logic                any_sel, grant;
   logic [IDX_W-1:0]    sel_idx;

   assign key_state = ~stable;
   assign tick      = (tick_cnt == TICK_LAST);

   // Two-flop synchroniser for the asynchronous raw keys
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
      end
   end

   // Free-running sample tick counter, 0..SAMPLE_CYCLES-1
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // Debounce: stable follows sync only after two agreeing ticks
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         sample   <= '1;
         stable   <= '1;
         stable_q <= '1;
      end else begin
         stable_q <= stable;
         if (tick) begin
            sample <= sync2;
            stable <= (~(sync2 ^ sample) & sync2) | ((sync2 ^ sample) & stable);
         end
      end
   end

   // Event decode: press edge, release about to happen, repeat expiry
   always_comb begin
      press       = stable_q & ~stable;
      release_now = {NUM_KEYS{tick}} & ~stable & sync2 & sample;
      rep_evt     = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         // The tick that releases the key never fires a repeat
         rep_evt[i] = (REPEAT_TICKS > 0) && tick && !stable[i] && !press[i]
                      && !release_now[i] && (rep_cnt[i] == REP_LAST);
      end
      evt = press | rep_evt;
   end

   // Per-key repeat counters: count ticks while held, clear on press/release
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            rep_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (press[i] || stable[i] || release_now[i]) begin
               rep_cnt[i] <= '0;
            end else if (tick) begin
               if (rep_cnt[i] == REP_LAST) begin
                  rep_cnt[i] <= '0;
               end else begin
                  rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
               end
            end
         end
      end
   end

   // Lowest-index pending key wins when the FSM can start a byte
   always_comb begin
      any_sel  = 1'b0;
      sel_idx  = '0;
      clr_mask = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (pending[i] && !any_sel) begin
            any_sel = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
      grant = (state == IDLE) && !uart_busy && any_sel;
      if (grant) begin
         clr_mask[sel_idx] = 1'b1;
      end
   end

   // Pending requests; an event wins over a same-cycle clear
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         pending    <= '0;
         drop_pulse <= 1'b0;
      end else begin
         pending    <= (pending & ~clr_mask) | evt;
         drop_pulse <= |(evt & pending & ~clr_mask);
      end
   end

   // Transmit FSM with registered strobe and data
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         state       <= IDLE;
         uart_wrsig  <= 1'b0;
         uart_datain <= '0;
         to_cnt      <= '0;
      end else begin
         uart_wrsig <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  uart_datain <= BASE_CODE + 8'(sel_idx);
                  uart_wrsig  <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: begin
               // Strobe cycle counts as the first cycle of the busy timeout
               to_cnt <= TO_W'(1);
               state  <= WAIT_START;
            end
            WAIT_START: begin
               if (uart_busy) begin
                  state <= WAIT_DONE;
               end else if (to_cnt >= TO_LAST) begin
                  state <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!uart_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/key_scan_tx.md
# key_scan_tx

Parametrised key-to-UART byte generator for NUM_KEYS active-low push keys. It synchronises and debounces every key on a shared sample tick, and queues each press (plus optional auto-repeat while held) as a pending request. It then emits one byte per request to the UART transmitter using a wrsig/busy handshake, so simultaneous presses are all delivered rather than dropped. It sits between the board keys and the uart transmitter in the top level.

## Interface
- NUM_KEYS, 4: number of keys, 1..8.
- SAMPLE_CYCLES, 1000000: clocks per debounce sample tick (20 ms at 50 MHz); at least 2.
- BASE_CODE, 8'd49: byte sent for key 0; key i sends BASE_CODE+i, mod 256 (ASCII '1'..).
- REPEAT_TICKS, 0: ticks between auto-repeats while a key is held; 0 disables repeat.
- BUSY_TIMEOUT, 16: clocks to wait for uart_busy to rise after a send.
- clk_50MHz  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- key  in  NUM_KEYS  raw keys, asynchronous, 0 = pressed.
- uart_busy  in  1  transmitter busy, 1 = byte in flight.
- uart_wrsig  out  1  one-cycle write strobe to the transmitter.
- uart_datain  out  8  byte to send; valid while uart_wrsig=1.
- key_state  out  NUM_KEYS  debounced state, 1 = pressed.
- drop_pulse  out  1  one-cycle pulse when an event merges into an already pending request.

## Operation
- Reset (rst_n=0 at a clock edge) clears the following, all within one cycle, regardless of FSM state (a send in progress is abandoned):
  - sync flops, sample and stable registers (to 1 = released);
  - tick counter, repeat counters, pending bits;
  - uart_wrsig=0, uart_datain=0, key_state=0, drop_pulse=0.
- Input path: 2-flop synchroniser per key.
- Tick: counter runs 0..SAMPLE_CYCLES-1; tick=1 for the one cycle when counter==SAMPLE_CYCLES-1, then wraps to 0.
- Debounce, on each tick for every key:
  - sample <= sync;
  - if sync==sample (two consecutive agreeing ticks), stable <= sync.
  - key_state = ~stable.
- Press event: stable goes 1->0.
- Repeat event (REPEAT_TICKS>0 only):
  - a per-key counter clears on the press event and counts ticks while stable=0;
  - on reaching REPEAT_TICKS it raises an event and clears;
  - release (stable 0->1) clears the counter with no event.
- Pending: an event sets pending[i].
  - If pending[i] is already 1, it stays 1 and drop_pulse=1 for one cycle.
  - An event on the same cycle the arbiter clears pending[i] leaves pending[i]=1, with no drop.
- FSM states:
  - IDLE: if any pending and uart_busy=0, select the lowest-index pending key, latch uart_datain=BASE_CODE+i, clear pending[i], go SEND.
  - SEND: uart_wrsig=1 for exactly this cycle; go WAIT_START.
  - WAIT_START: if uart_busy=1, go WAIT_DONE. After BUSY_TIMEOUT cycles without busy, go IDLE.
  - WAIT_DONE: when uart_busy=0, go IDLE.
- uart_datain holds its last value outside SEND.
- Events keep being captured in every FSM state.

## Timing
- Raw key edge to sync output: 2 cycles.
- Sync change to stable change: the second tick that samples the new value, i.e. 1 to 2 tick periods.
- Stable 1->0 to pending set: 1 cycle.
- Pending set (FSM in IDLE, uart_busy=0) to uart_wrsig=1: 2 cycles (IDLE select, SEND).
- Back-to-back bytes: the next IDLE selection happens the cycle after busy falls.
- Glitches shorter than one tick period never change stable.
- A key released and re-pressed within one tick is not seen.

## Test plan
- Single press: SAMPLE_CYCLES=4, key[2] held low for 40 cycles, uart_busy model high for 20 cycles per byte. Required: exactly one uart_wrsig pulse with uart_datain=8'd51; key_state[2]=1 while held.
- Bounce rejection: key[0] toggled every 2 cycles for 30 cycles, then released. Required: no uart_wrsig; key_state stays 0.
- Simultaneous press: key[3] and key[1] fall on the same cycle. Required: two bytes in order 8'd50 then 8'd52; the second strobe comes only after busy falls.
- Auto-repeat: REPEAT_TICKS=3, key[0] held 12 ticks. Required: 8'd49 sent once on press plus once per 3 ticks held, 4 bytes total; none after release.
- Merge/drop and timeout: uart_busy held 1 while key[0] is pressed twice. Required: one drop_pulse and a single 8'd49 after busy falls. Separately, with busy never rising, the FSM returns to IDLE 16 cycles after the strobe.
- Reset mid-operation: assert rst_n=0 during WAIT_DONE with pending bits set. Required: next cycle uart_wrsig=0, uart_datain=0, key_state=0, and no byte sent after release of reset unless a new press occurs.
